// File: rtl/trng_pkg.sv
// Shared types for the TRNG byte transmitter: TX handshake states and byte width.
package trng_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE
    } tx_state_e;
endpackage

// File: rtl/trng_fifo.sv
// Synchronous byte FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module trng_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        dout    = mem_q[rd_q];
        count   = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/trng_byte_tx.sv
// Samples RO outputs, XOR-folds and von Neumann-debiases them, packs bytes and
// sends them to the MCU over a 4-phase strobe/ack handshake.
module trng_byte_tx import trng_pkg::*; #(
    parameter int N          = 10,
    parameter int SAMPLE_DIV = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [N-1:0]                      RO_IN,
    input  logic                              EN,
    output logic [BYTE_W-1:0]                 CM_OUT,
    output logic                              CM_STB,
    input  logic                              CM_ACK,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_CNT,
    output logic                              OVERFLOW
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [N-1:0]      ro_s1_q, ro_s2_q;
    logic              ack_s1_q, ack_s2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              have_q, have_d, held_q, held_d;
    logic [BYTE_W-1:0] sr_q, sr_d, byte_nxt;
    logic [2:0]        pcnt_q, pcnt_d;
    logic              ovf_q, ovf_d;
    logic              sample, raw, emit, push, pop;
    logic              fifo_full, fifo_empty;
    logic [BYTE_W-1:0] fifo_dout;
    tx_state_e         state_q;
    logic [BYTE_W-1:0] cm_out_q;
    logic              cm_stb_q;

    always_comb begin
        sample   = EN && (div_q == DIV_W'(SAMPLE_DIV-1));
        raw      = ^ro_s2_q;
        emit     = sample && have_q && (held_q != raw);
        byte_nxt = {sr_q[BYTE_W-2:0], held_q};
        push     = emit && (pcnt_q == 3'd7);
        pop      = (state_q == IDLE) && !fifo_empty;
        div_d    = sample ? '0 : div_q + DIV_W'(1);
        have_d   = sample ? !have_q : have_q;
        held_d   = (sample && !have_q) ? raw : held_q;
        sr_d     = emit ? byte_nxt : sr_q;
        pcnt_d   = emit ? pcnt_q + 3'd1 : pcnt_q;
        // Disabling collection discards any partial sample/pair/byte state.
        if (!EN) begin
            div_d  = '0;
            have_d = 1'b0;
            held_d = 1'b0;
            sr_d   = '0;
            pcnt_d = '0;
        end
        ovf_d    = ovf_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ro_s1_q  <= '0;
            ro_s2_q  <= '0;
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            div_q    <= '0;
            have_q   <= 1'b0;
            held_q   <= 1'b0;
            sr_q     <= '0;
            pcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ro_s1_q  <= RO_IN;
            ro_s2_q  <= ro_s1_q;
            ack_s1_q <= CM_ACK;
            ack_s2_q <= ack_s1_q;
            div_q    <= div_d;
            have_q   <= have_d;
            held_q   <= held_d;
            sr_q     <= sr_d;
            pcnt_q   <= pcnt_d;
            ovf_q    <= ovf_d;
        end
    end

    trng_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .din   (byte_nxt),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (FIFO_CNT)
    );

    // CM_OUT is loaded when leaving IDLE and held until the next byte is popped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cm_out_q <= '0;
            cm_stb_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!fifo_empty) begin
                    cm_out_q <= fifo_dout;
                    state_q  <= SETUP;
                end
                SETUP: begin
                    cm_stb_q <= 1'b1;
                    state_q  <= STROBE;
                end
                STROBE: if (ack_s2_q) begin
                    cm_stb_q <= 1'b0;
                    state_q  <= RELEASE;
                end
                RELEASE: if (!ack_s2_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CM_OUT   = cm_out_q;
    assign CM_STB   = cm_stb_q;
    assign OVERFLOW = ovf_q;
endmodule
